// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter driving a 2:1 mux select and a one-entry output register.
// Define MUX2_ARB_STATS_EN to add saturating per-source accepted-word counters.
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ready_o,
  output logic             sel_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_data_o,
`ifdef MUX2_ARB_STATS_EN
  output logic [15:0]      a_count_o,
  output logic [15:0]      b_count_o,
`endif
  input  logic             y_ready_i
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             load;
  logic             grantA;
  logic             grantB;

  assign load = (state_q == EMPTY) | y_ready_i;

  // last_q = 1 means B won most recently, so A takes the next tie.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (load && !rst_i) begin
      if (a_valid_i && !b_valid_i) begin
        grantA = 1'b1;
      end else if (b_valid_i && !a_valid_i) begin
        grantB = 1'b1;
      end else if (a_valid_i && b_valid_i) begin
        grantA = last_q;
        grantB = !last_q;
      end
    end
  end

  assign a_ready_o = grantA;
  assign b_ready_o = grantB;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (grantA || grantB) begin
      state_d = FULL;
      data_d  = grantB ? b_data_i : a_data_i;
      sel_d   = grantB;
      last_d  = grantB;
    end else if (y_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign y_valid_o = (state_q == FULL);
  assign y_data_o  = data_q;
  assign sel_o     = sel_q;

`ifdef MUX2_ARB_STATS_EN
  logic [15:0] a_count_q, a_count_d;
  logic [15:0] b_count_q, b_count_d;

  always_comb begin
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (grantA && a_count_q != 16'hFFFF) a_count_d = a_count_q + 16'd1;
    if (grantB && b_count_q != 16'hFFFF) b_count_d = b_count_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign a_count_o = a_count_q;
  assign b_count_o = b_count_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed plan plus random traffic against a transaction-level model.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       aValid, bValid, yReady;
  logic [7:0] aData, bData;
  logic       aReady, bReady, sel, yValid;
  logic [7:0] yData;
`ifdef MUX2_ARB_STATS_EN
  logic [15:0] aCount, bCount;
  int          mCountA, mCountB;
`endif

  int tests = 0;
  int fails = 0;

  // Model: what the consumer should see, and which source won the previous contest.
  logic       mFull;
  logic [7:0] mWord;
  logic       mFromB;
  logic       lastWinnerB;
  logic       tookA, tookB;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .a_valid_i(aValid),
    .a_data_i(aData),
    .a_ready_o(aReady),
    .b_valid_i(bValid),
    .b_data_i(bData),
    .b_ready_o(bReady),
    .sel_o(sel),
    .y_valid_o(yValid),
    .y_data_o(yData),
`ifdef MUX2_ARB_STATS_EN
    .a_count_o(aCount),
    .b_count_o(bCount),
`endif
    .y_ready_i(yReady)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of traffic: check the combinational readies, advance the model, check registers.
  task automatic applyStimulus(input logic r, input logic av, input logic [7:0] ad,
                               input logic bv, input logic [7:0] bd, input logic yr);
    logic roomForWord;
    @(negedge clk);
    rst = r; aValid = av; aData = ad; bValid = bv; bData = bd; yReady = yr;
    #1;
    roomForWord = !mFull || yr;
    tookA = 1'b0;
    tookB = 1'b0;
    if (!r && roomForWord) begin
      if (av && bv) begin
        if (lastWinnerB) tookA = 1'b1; else tookB = 1'b1;
      end else begin
        tookA = av;
        tookB = bv;
      end
    end
    checkOutput("a_ready", aReady, tookA);
    checkOutput("b_ready", bReady, tookB);
    @(posedge clk);
    if (r) begin
      mFull = 0; mWord = 0; mFromB = 0; lastWinnerB = 1;
`ifdef MUX2_ARB_STATS_EN
      mCountA = 0; mCountB = 0;
`endif
    end else if (tookA || tookB) begin
      mFull = 1;
      mWord = tookA ? ad : bd;
      mFromB = tookB;
      lastWinnerB = tookB;
`ifdef MUX2_ARB_STATS_EN
      if (tookA && mCountA < 65535) mCountA++;
      if (tookB && mCountB < 65535) mCountB++;
`endif
    end else if (yr) begin
      mFull = 0;
    end
    #1;
    checkOutput("y_valid", yValid, mFull);
    checkOutput("y_data", yData, mWord);
    checkOutput("sel", sel, mFromB);
`ifdef MUX2_ARB_STATS_EN
    checkOutput("a_count", aCount, mCountA);
    checkOutput("b_count", bCount, mCountB);
`endif
  endtask

  logic       aPend, bPend;
  logic [7:0] aWord, bWord;

  initial begin
    rst = 1; aValid = 0; bValid = 0; aData = 0; bData = 0; yReady = 0;
    mFull = 0; mWord = 0; mFromB = 0; lastWinnerB = 1;
`ifdef MUX2_ARB_STATS_EN
    mCountA = 0; mCountB = 0;
`endif

    // Reset with both sources requesting, then the first tie goes to A.
    applyStimulus(1, 1, 8'h11, 1, 8'h22, 1);
    applyStimulus(1, 1, 8'h11, 1, 8'h22, 1);
    applyStimulus(0, 1, 8'h11, 1, 8'h22, 1);
    checkOutput("first_tie_sel", sel, 0);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

    // Single source A.
    applyStimulus(0, 1, 8'hA5, 0, 8'h00, 1);
    checkOutput("a_only_data", yData, 8'hA5);

    // Continuous contention alternates; explicit expected sequence after the A-only word.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 8'h11, 1, 8'h22, 1);
      checkOutput("alt_data", yData, (i % 2 == 0) ? 8'h22 : 8'h11);
    end

    // Backpressure with B pending, then release.
    applyStimulus(0, 1, 8'h33, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, 8'h44, 0);
    checkOutput("stall_data", yData, 8'h33);
    applyStimulus(0, 0, 8'h00, 1, 8'h44, 1);
    checkOutput("release_data", yData, 8'h44);

    // Drain with nobody requesting.
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
    checkOutput("drain_valid", yValid, 0);
    checkOutput("drain_hold", yData, 8'h44);

`ifdef MUX2_ARB_STATS_EN
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'(i), 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, 8'(i), 1);
    checkOutput("count_a5", aCount, 5);
    checkOutput("count_b3", bCount, 3);
    @(negedge clk);
    force dut.a_count_q = 16'hFFFF;
    #1;
    release dut.a_count_q;
    mCountA = 65535;
    applyStimulus(0, 1, 8'h77, 0, 8'h00, 1);
    checkOutput("count_sat", aCount, 16'hFFFF);
`endif

    // Random traffic; sources hold their word until it is accepted.
    aPend = 0; bPend = 0; aWord = 0; bWord = 0;
    for (int i = 0; i < 400; i++) begin
      if (!aPend && $urandom_range(0, 99) < 60) begin aPend = 1; aWord = 8'($urandom); end
      if (!bPend && $urandom_range(0, 99) < 60) begin bPend = 1; bWord = 8'($urandom); end
      applyStimulus(($urandom_range(0, 99) < 3), aPend, aPend ? aWord : 8'($urandom),
                    bPend, bPend ? bWord : 8'($urandom), ($urandom_range(0, 99) < 65));
      if (tookA) aPend = 0;
      if (tookB) bPend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
